opnd_fetch: RTL and testbench

//  Operand-fetch client of the triple-ported register file: the issue stage sends a request with
//  two register numbers; this block drives the file's read ports and absorbs its 1-cycle read latency.
//  It returns both 32-bit operands with a tag over a valid/ready handshake.
//  It snoops the file's write port and forwards write data, so operands always reflect the latest writes.
//  It sits between the decode/issue stage and the execute stage of the RISC5 core.

---
 rtl/cpu_pkg.sv | 11 +
 rtl/opnd_slot.sv | 67 ++++++
 rtl/opnd_fetch.sv | 115 +++++++++++
 tb/tb_opnd_fetch.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared RISC5 core constants.
//   REG_AW   : register number width
//   DATA_W   : register data width
//   NUM_REGS : number of architectural registers (all ordinary, no hardwired zero)
//   NUM_OPND : operands fetched per request (A, B)
package cpu_pkg;
    localparam int REG_AW   = 4;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;
    localparam int NUM_OPND = 2;
endpackage

// File: rtl/opnd_slot.sv
// One operand lane of the operand-fetch block.
// Holds the same-cycle forwarding flag/data, the stall hold register, the
// latched register number, and the late-bypass mux on the output.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   flush         discard forwarding state
//   accept        request accepted this cycle (latch register number, fwd)
//   first         first output cycle of the presented pair
//   stall         pair presented but not taken this cycle
//   req_reg       register number of the incoming request
//   rd_data       register file read data (1-cycle latency)
//   wr_en/reg/data snooped register file write port
//   op            operand value presented to the consumer
module opnd_slot
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              accept,
    input  logic              first,
    input  logic              stall,
    input  logic [REG_AW-1:0] req_reg,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_reg,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] op
);

    logic [REG_AW-1:0] s_reg;
    logic              fwd;
    logic [DATA_W-1:0] fwd_data;
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] base;
    logic [DATA_W-1:0] op_byp;

    // The file returns pre-write data when a write lands in the accept cycle,
    // so that write is captured here and substituted for rd_data next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_reg    <= '0;
            fwd      <= 1'b0;
            fwd_data <= '0;
            hold     <= '0;
        end else if (flush) begin
            fwd      <= 1'b0;
        end else if (accept) begin
            s_reg    <= req_reg;
            fwd      <= wr_en && (wr_reg == req_reg);
            fwd_data <= wr_data;
        end else if (stall) begin
            // Capture what is displayed (including any late bypass) so the
            // value survives rd_data changing underneath a stalled pair.
            hold     <= op_byp;
        end
    end

    always_comb begin
        base = hold;
        if (first)
            base = fwd ? fwd_data : rd_data;
        op_byp = (wr_en && (wr_reg == s_reg)) ? wr_data : base;
        op     = rst ? '0 : op_byp;
    end

endmodule

// File: rtl/opnd_fetch.sv
// Operand-fetch client of the triple-ported register file.
// Accepts {req_a, req_b, req_tag} over a valid/ready handshake, drives the
// file's read ports combinationally, absorbs the 1-cycle read latency and
// presents {op_a, op_b, op_tag} over a valid/ready handshake. Snooped writes
// are forwarded so the operands always reflect the latest register contents.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    discard any in-flight/held pair, block accepts
//   req_valid/ready/a/b/tag  request side (issue stage)
//   rd_reg_1/2, rd_data_1/2  register file read ports
//   wr_reg/wr_data/wr_en     snooped register file write port
//   op_valid/ready/a/b/tag   operand side (execute stage)
module opnd_fetch
    import cpu_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [REG_AW-1:0] req_a,
    input  logic [REG_AW-1:0] req_b,
    input  logic [TAG_W-1:0]  req_tag,
    output logic [REG_AW-1:0] rd_reg_1,
    output logic [REG_AW-1:0] rd_reg_2,
    input  logic [DATA_W-1:0] rd_data_1,
    input  logic [DATA_W-1:0] rd_data_2,
    input  logic [REG_AW-1:0] wr_reg,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [TAG_W-1:0]  op_tag
);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_FIRST,
        S_HELD
    } state_t;

    state_t                              state, state_nx;
    logic [TAG_W-1:0]                    tag_q;
    logic                                accept;
    logic                                stall;
    logic                                first;
    logic [NUM_OPND-1:0][REG_AW-1:0]     req_reg_v;
    logic [NUM_OPND-1:0][DATA_W-1:0]     rd_data_v;
    logic [NUM_OPND-1:0][DATA_W-1:0]     op_v;

    assign rd_reg_1 = req_a;
    assign rd_reg_2 = req_b;

    assign op_valid  = (state != S_EMPTY);
    assign first     = (state == S_FIRST);
    assign req_ready = !rst && !flush && (!op_valid || op_ready);
    assign accept    = req_valid && req_ready;
    assign stall     = op_valid && !op_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_EMPTY;
            tag_q <= '0;
        end else begin
            state <= state_nx;
            if (accept)
                tag_q <= req_tag;
        end
    end

    // flush dominates; an accept always starts a fresh pair in S_FIRST.
    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = S_EMPTY;
        end else if (accept) begin
            state_nx = S_FIRST;
        end else begin
            case (state)
                S_FIRST: state_nx = op_ready ? S_EMPTY : S_HELD;
                S_HELD:  state_nx = op_ready ? S_EMPTY : S_HELD;
                default: state_nx = S_EMPTY;
            endcase
        end
    end

    assign req_reg_v = {req_b, req_a};
    assign rd_data_v = {rd_data_2, rd_data_1};

    for (genvar i = 0; i < NUM_OPND; i++) begin : g_slot
        opnd_slot u_slot (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush),
            .accept  (accept),
            .first   (first),
            .stall   (stall),
            .req_reg (req_reg_v[i]),
            .rd_data (rd_data_v[i]),
            .wr_en   (wr_en),
            .wr_reg  (wr_reg),
            .wr_data (wr_data),
            .op      (op_v[i])
        );
    end

    assign op_a   = op_v[0];
    assign op_b   = op_v[1];
    assign op_tag = rst ? '0 : tag_q;

endmodule

// File: tb/tb_opnd_fetch.sv
// Bench for opnd_fetch: behavioural register file plus a transaction-level
// reference (one pending pair, operands = current architectural register
// value with same-cycle write visibility).
module tb_opnd_fetch;

    localparam int TAG_W = 4;

    logic        clk = 1'b0;
    logic        rst, flush, req_valid, op_ready, wr_en;
    logic [3:0]  req_a, req_b, wr_reg;
    logic [TAG_W-1:0] req_tag;
    logic [31:0] wr_data;
    logic [3:0]  rd_reg_1, rd_reg_2;
    logic [31:0] rd_data_1, rd_data_2;
    logic        req_ready, op_valid;
    logic [31:0] op_a, op_b;
    logic [TAG_W-1:0] op_tag;

    int n_vec = 0;
    int n_err = 0;

    // Register file at power-up contents; 1-cycle read, reads see pre-write data.
    logic [31:0] regs [16] = '{
        32'h025DE15E, 32'h0D4D67E6, 32'h6D6228D3, 32'h3ECC6079,
        32'h4A3B2C1D, 32'h1D44B8B0, 32'h77A1B2C3, 32'h3C61EE4A,
        32'h11112222, 32'h5A5A0F0F, 32'h0BADC0DE, 32'h600DF00D,
        32'h13572468, 32'h7E7E1818, 32'h2468ACE0, 32'h55AA33CC
    };

    always @(posedge clk) begin
        rd_data_1 <= regs[rd_reg_1];
        rd_data_2 <= regs[rd_reg_2];
        if (wr_en) regs[wr_reg] <= wr_data;
    end

    always #5 clk = ~clk;

    opnd_fetch #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .rd_reg_1(rd_reg_1), .rd_reg_2(rd_reg_2),
        .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
        .wr_reg(wr_reg), .wr_data(wr_data), .wr_en(wr_en),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .op_tag(op_tag)
    );

    // Reference: at most one pair outstanding.
    logic             m_valid = 1'b0;
    logic [TAG_W-1:0] m_tag   = '0;
    logic [3:0]       m_a     = '0;
    logic [3:0]       m_b     = '0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    function automatic logic [31:0] arch_val(input logic [3:0] r);
        return (wr_en && wr_reg == r) ? wr_data : regs[r];
    endfunction

    task automatic check_outputs();
        logic exp_rdy;
        exp_rdy = !rst && !flush && (!m_valid || op_ready);
        chk("req_ready", {31'b0, req_ready}, {31'b0, exp_rdy});
        chk("op_valid", {31'b0, op_valid}, {31'b0, m_valid});
        chk("rd_reg_1", {28'b0, rd_reg_1}, {28'b0, req_a});
        chk("rd_reg_2", {28'b0, rd_reg_2}, {28'b0, req_b});
        if (rst) begin
            chk("op_a_rst", op_a, 32'h0);
            chk("op_b_rst", op_b, 32'h0);
            chk("op_tag_rst", {28'b0, op_tag}, 32'h0);
        end else if (m_valid) begin
            chk("op_a", op_a, arch_val(m_a));
            chk("op_b", op_b, arch_val(m_b));
            chk("op_tag", {28'b0, op_tag}, {28'b0, m_tag});
        end
    endtask

    task automatic update_model();
        logic acc;
        acc = !rst && !flush && req_valid && (!m_valid || op_ready);
        if (rst) begin
            m_valid = 1'b0;
            m_tag   = '0;
        end else if (flush) begin
            m_valid = 1'b0;
        end else if (acc) begin
            m_valid = 1'b1;
            m_tag   = req_tag;
            m_a     = req_a;
            m_b     = req_b;
        end else if (m_valid && op_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic half_a();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic half_b();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic step();
        half_a();
        half_b();
    endtask

    task automatic idle_inputs();
        flush = 0; req_valid = 0; req_a = 0; req_b = 0; req_tag = 0;
        wr_en = 0; wr_reg = 0; wr_data = 0;
    endtask

    logic [31:0] t4 [4];

    initial begin
        t4[0] = 32'h025DE15E; t4[1] = 32'h0D4D67E6;
        t4[2] = 32'h6D6228D3; t4[3] = 32'h3ECC6079;
        idle_inputs();
        op_ready = 1; rst = 1;
        #1;
        step(); step();
        rst = 0;
        half_a();
        chk("reset_op_tag", {28'b0, op_tag}, 32'h0);
        half_b();

        // Basic fetch a=3 b=5 tag=1.
        req_valid = 1; req_a = 3; req_b = 5; req_tag = 1; op_ready = 1;
        step();
        idle_inputs();
        half_a();
        chk("t1_valid", {31'b0, op_valid}, 32'h1);
        chk("t1_a", op_a, 32'h3ECC6079);
        chk("t1_b", op_b, 32'h1D44B8B0);
        chk("t1_tag", {28'b0, op_tag}, 32'h1);
        half_b();
        half_a();
        chk("t1_drain", {31'b0, op_valid}, 32'h0);
        half_b();

        // Same-cycle write hazard on r7.
        req_valid = 1; req_a = 7; req_b = 7; req_tag = 4;
        wr_en = 1; wr_reg = 7; wr_data = 32'hDEADBEEF;
        step();
        idle_inputs();
        half_a();
        chk("t2_a", op_a, 32'hDEADBEEF);
        chk("t2_b", op_b, 32'hDEADBEEF);
        half_b();

        // Stall for 3 cycles with a write to r5 in stall cycle 2.
        req_valid = 1; req_a = 2; req_b = 5; req_tag = 2; op_ready = 0;
        step();
        idle_inputs();
        half_a();
        chk("t3_b_s1", op_b, 32'h1D44B8B0);
        half_b();
        wr_en = 1; wr_reg = 5; wr_data = 32'h12345678;
        half_a();
        chk("t3_b_s2", op_b, 32'h12345678);
        half_b();
        idle_inputs();
        half_a();
        chk("t3_b_s3", op_b, 32'h12345678);
        chk("t3_a_s3", op_a, 32'h6D6228D3);
        chk("t3_tag", {28'b0, op_tag}, 32'h2);
        half_b();
        op_ready = 1;
        step();

        // Four back-to-back requests.
        for (int i = 0; i < 4; i++) begin
            req_valid = 1; req_a = 4'(i); req_b = 4'(i); req_tag = 4'(i);
            half_a();
            chk("t4_ready", {31'b0, req_ready}, 32'h1);
            if (i > 0) chk("t4_a", op_a, t4[i-1]);
            half_b();
        end
        idle_inputs();
        half_a();
        chk("t4_a_last", op_a, t4[3]);
        half_b();

        // Flush a stalled pair while a request is offered.
        req_valid = 1; req_a = 4; req_b = 6; req_tag = 5; op_ready = 0;
        step();
        idle_inputs();
        step();
        flush = 1; req_valid = 1; req_a = 8; req_tag = 6;
        half_a();
        chk("t5_ready_flush", {31'b0, req_ready}, 32'h0);
        half_b();
        idle_inputs();
        half_a();
        chk("t5_valid", {31'b0, op_valid}, 32'h0);
        chk("t5_ready_after", {31'b0, req_ready}, 32'h1);
        half_b();

        // Reset during a stall with forwarding armed on A.
        req_valid = 1; req_a = 9; req_b = 10; req_tag = 7; op_ready = 0;
        wr_en = 1; wr_reg = 9; wr_data = 32'hCAFEF00D;
        step();
        idle_inputs();
        step();
        rst = 1;
        step();
        rst = 0;
        half_a();
        chk("t6_valid", {31'b0, op_valid}, 32'h0);
        chk("t6_a", op_a, 32'h0);
        half_b();
        req_valid = 1; req_a = 1; req_b = 1; req_tag = 3; op_ready = 1;
        step();
        idle_inputs();
        half_a();
        chk("t6_fresh_a", op_a, 32'h0D4D67E6);
        half_b();

        // Randomized traffic with writes biased onto the requested registers.
        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(0, 63) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            req_valid = $urandom_range(0, 1) == 1;
            op_ready  = $urandom_range(0, 3) != 0;
            req_a     = 4'($urandom_range(0, 1) == 1 ? $urandom_range(0, 3) : $urandom_range(0, 15));
            req_b     = 4'($urandom_range(0, 1) == 1 ? $urandom_range(0, 3) : $urandom_range(0, 15));
            req_tag   = 4'($urandom_range(0, 15));
            wr_en     = $urandom_range(0, 1) == 1;
            wr_reg    = 4'($urandom_range(0, 1) == 1 ? $urandom_range(0, 3) : $urandom_range(0, 15));
            wr_data   = $urandom;
            step();
        end
        rst = 0;
        idle_inputs();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
